sobel_stream_filter: RTL and testbench

Streaming, parametrised successor to the fixed-size Sobel block. It accepts a raster-order grayscale frame one pixel per valid beat and keeps the last two image rows in internal line buffers. It emits one edge-magnitude pixel per interior window: a saturated |Gx|+|Gy| value, or a binary edge map against a runtime threshold. It sits between the grayscale pixel source and the processed-image sink on the Avalon-facing datapath.

---
 rtl/sobel_pkg.sv | 18 +
 rtl/sobel_line_buffer.sv | 44 ++++
 rtl/sobel_stream_filter.sv | 189 ++++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge filter.
// Holds FSM states, output mode encodings and the magnitude width rule.
package sobel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_MAG = 1'b0;
    localparam logic MODE_THR = 1'b1;

    // |Gx|+|Gy| never exceeds 8*(2^PIX_W-1), so three extra bits suffice.
    function automatic int mag_w(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of storage with a circular address.
// Read returns the entry about to be overwritten, i.e. the pixel one row back.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;
    logic             w_ptr_end;

    assign w_ptr_end = (r_ptr == AW'(DEPTH - 1));
    assign rd_data_o = r_mem[r_ptr];

    // Circular pointer: restarts at each frame and wraps once per row.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (clr_i) begin
            r_ptr <= '0;
        end else if (wr_en_i) begin
            r_ptr <= w_ptr_end ? '0 : r_ptr + AW'(1);
        end
    end

    // Storage array is left uninitialised so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[r_ptr] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel filter over a raster-order grayscale frame.
// Emits saturated |Gx|+|Gy| or a binary edge map for interior pixels.
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [mag_w(PIX_W)-1:0]   threshold_i,
    input  logic                      pix_valid_i,
    input  logic [PIX_W-1:0]          GrayImage_i,
    output logic                      busy_o,
    output logic                      valid_o,
    output logic [PIX_W-1:0]          ProcessedImagePixel_o,
    output logic                      done_o
);

    localparam int MAG_W = mag_w(PIX_W);
    localparam int GW    = PIX_W + 4;
    localparam int SW    = PIX_W + 2;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    localparam logic [GW-1:0]    SAT     = GW'((1 << PIX_W) - 1);
    localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};

    state_t r_state;
    state_t w_state_nx;

    logic                  r_mode;
    logic [MAG_W-1:0]      r_thr;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [2:0][2:0][PIX_W-1:0] r_win;
    logic                  r_fire;
    logic                  r_last;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_x_end;
    logic             w_y_end;
    logic [PIX_W-1:0] w_lb1_rd;
    logic [PIX_W-1:0] w_lb2_rd;
    logic [SW-1:0]    w_xr;
    logic [SW-1:0]    w_xl;
    logic [SW-1:0]    w_yb;
    logic [SW-1:0]    w_yt;
    logic [GW-1:0]    w_gx;
    logic [GW-1:0]    w_gy;
    logic [GW-1:0]    w_ax;
    logic [GW-1:0]    w_ay;
    logic [GW-1:0]    w_mag;
    logic [PIX_W-1:0] w_out;

    assign w_start_ok = (r_state == IDLE) && start_i;
    assign w_accept   = (r_state == RUN) && pix_valid_i && !r_last;
    assign w_x_end    = (r_x == XW'(IMG_W - 1));
    assign w_y_end    = (r_y == YW'(IMG_H - 1));
    assign busy_o     = (r_state == RUN);

    // Row y-1 buffer feeds the row y-2 buffer with the pixel it displaces.
    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_start_ok),
        .wr_en_i   (w_accept),
        .wr_data_i (GrayImage_i),
        .rd_data_o (w_lb1_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb2 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_start_ok),
        .wr_en_i   (w_accept),
        .wr_data_i (w_lb1_rd),
        .rd_data_o (w_lb2_rd)
    );

    // Frame state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state: arm on start, finish when the last output registers.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: if (start_i) w_state_nx = RUN;
            RUN:  if (r_last)  w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Frame configuration and raster position counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode <= MODE_MAG;
            r_thr  <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (w_start_ok) begin
            r_mode <= mode_i;
            r_thr  <= threshold_i;
            r_x    <= '0;
            r_y    <= '0;
        end else if (w_accept) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // 3x3 window shifts left; newest column enters at c=2.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_win  <= '0;
            r_fire <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_fire <= w_accept && (r_x >= XW'(2)) && (r_y >= YW'(2));
            r_last <= w_accept && w_x_end && w_y_end;
            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb2_rd;
                r_win[1][2] <= w_lb1_rd;
                r_win[2][2] <= GrayImage_i;
            end
        end
    end

    assign w_xr = SW'(r_win[0][2]) + SW'({r_win[1][2], 1'b0}) + SW'(r_win[2][2]);
    assign w_xl = SW'(r_win[0][0]) + SW'({r_win[1][0], 1'b0}) + SW'(r_win[2][0]);
    assign w_yb = SW'(r_win[2][0]) + SW'({r_win[2][1], 1'b0}) + SW'(r_win[2][2]);
    assign w_yt = SW'(r_win[0][0]) + SW'({r_win[0][1], 1'b0}) + SW'(r_win[0][2]);

    assign w_gx  = GW'(w_xr) - GW'(w_xl);
    assign w_gy  = GW'(w_yb) - GW'(w_yt);
    assign w_ax  = w_gx[GW-1] ? (~w_gx + GW'(1)) : w_gx;
    assign w_ay  = w_gy[GW-1] ? (~w_gy + GW'(1)) : w_gy;
    assign w_mag = w_ax + w_ay;

    // Output pixel: saturated magnitude or thresholded edge flag.
    always_comb begin
        w_out = '0;
        if (r_mode == MODE_THR) begin
            w_out = (w_mag > GW'(r_thr)) ? PIX_MAX : '0;
        end else begin
            w_out = (w_mag > SAT) ? PIX_MAX : w_mag[PIX_W-1:0];
        end
    end

    // Output register stage; pixel value holds between pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o               <= 1'b0;
            done_o                <= 1'b0;
            ProcessedImagePixel_o <= '0;
        end else begin
            valid_o <= r_fire;
            done_o  <= r_last;
            if (r_fire) begin
                ProcessedImagePixel_o <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter on 3x3 and 4x4 frames.
// Directed frames push expected pixels; per-DUT monitors pop and compare.
module tb_sobel_stream_filter;

    typedef struct {
        logic [7:0] pix;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start3, start4;
    logic        mode;
    logic [10:0] thr;
    logic        pv;
    logic [7:0]  gray;

    logic        busy3, valid3, done3;
    logic [7:0]  pix3;
    logic        busy4, valid4, done4;
    logic [7:0]  pix4;

    exp_t q3[$];
    exp_t q4[$];
    int   fbuf[16];
    int   last_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sobel_stream_filter #(.PIX_W(8), .IMG_W(3), .IMG_H(3)) u3 (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .start_i               (start3),
        .mode_i                (mode),
        .threshold_i           (thr),
        .pix_valid_i           (pv),
        .GrayImage_i           (gray),
        .busy_o                (busy3),
        .valid_o               (valid3),
        .ProcessedImagePixel_o (pix3),
        .done_o                (done3)
    );

    sobel_stream_filter #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u4 (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .start_i               (start4),
        .mode_i                (mode),
        .threshold_i           (thr),
        .pix_valid_i           (pv),
        .GrayImage_i           (gray),
        .busy_o                (busy4),
        .valid_o               (valid4),
        .ProcessedImagePixel_o (pix4),
        .done_o                (done4)
    );

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int qsz(input int sel);
        return (sel == 3) ? q3.size() : q4.size();
    endfunction

    task automatic push(input int sel, input int p, input bit d);
        exp_t e;
        e.pix = 8'(p);
        e.done = d;
        if (sel == 3) q3.push_back(e);
        else q4.push_back(e);
        last_exp = p;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (valid3) begin
                if (q3.size() == 0) chk("u3 unexpected valid", 1, 0);
                else begin
                    e = q3.pop_front();
                    chk("u3 pixel", int'(pix3), int'(e.pix));
                    chk("u3 done", int'(done3), int'(e.done));
                end
            end else if (done3) chk("u3 done without valid", 1, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (valid4) begin
                if (q4.size() == 0) chk("u4 unexpected valid", 1, 0);
                else begin
                    e = q4.pop_front();
                    chk("u4 pixel", int'(pix4), int'(e.pix));
                    chk("u4 done", int'(done4), int'(e.done));
                end
            end else if (done4) chk("u4 done without valid", 1, 0);
        end
    end

    task automatic run_frame(input int sel, input int n, input logic m,
                             input logic [10:0] t, input bit gaps, input bit mid_start);
        @(posedge clk); #1;
        if (sel == 3) start3 = 1'b1;
        else start4 = 1'b1;
        mode = m;
        thr  = t;
        @(posedge clk); #1;
        start3 = 1'b0;
        start4 = 1'b0;
        mode   = ~m;
        thr    = ~t;
        for (int i = 0; i < n; i++) begin
            pv   = 1'b1;
            gray = 8'(fbuf[i]);
            if (mid_start && i == 5) begin
                if (sel == 3) start3 = 1'b1;
                else start4 = 1'b1;
            end
            @(posedge clk); #1;
            start3 = 1'b0;
            start4 = 1'b0;
            if (gaps) begin
                pv = 1'b0;
                @(posedge clk); #1;
            end
        end
        pv = 1'b0;
        for (int k = 0; k < 20 && qsz(sel) != 0; k++) @(posedge clk);
        chk("scoreboard drained", qsz(sel), 0);
        @(negedge clk);
        chk("busy low after frame", (sel == 3) ? int'(busy3) : int'(busy4), 0);
        chk("pixel held", (sel == 3) ? int'(pix3) : int'(pix4), last_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start3 = 0; start4 = 0; mode = 0; thr = '0; pv = 0; gray = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy3", busy3, 0);
        chk("reset valid3", valid3, 0);
        chk("reset done3", done3, 0);
        chk("reset pix3", pix3, 0);
        chk("reset busy4", busy4, 0);
        chk("reset valid4", valid4, 0);
        chk("reset done4", done4, 0);
        chk("reset pix4", pix4, 0);
        rst = 1'b0;

        // pixels while idle must be ignored
        pv = 1'b1; gray = 8'd200;
        repeat (3) @(posedge clk);
        #1;
        pv = 1'b0;
        chk("idle pixels ignored", busy3, 0);

        for (int i = 0; i < 9; i++) fbuf[i] = 10 * (i + 1);
        push(3, 255, 1); run_frame(3, 9, 1'b0, 11'd0, 0, 0);
        push(3, 0, 1);   run_frame(3, 9, 1'b1, 11'd400, 0, 0);
        push(3, 255, 1); run_frame(3, 9, 1'b1, 11'd319, 0, 0);

        for (int i = 0; i < 9; i++) fbuf[i] = i;
        push(3, 32, 1);  run_frame(3, 9, 1'b0, 11'd0, 0, 0);
        push(3, 0, 1);   run_frame(3, 9, 1'b1, 11'd32, 0, 0);
        push(3, 255, 1); run_frame(3, 9, 1'b1, 11'd31, 0, 0);

        for (int i = 0; i < 16; i++) fbuf[i] = 77;
        push(4, 0, 0); push(4, 0, 0); push(4, 0, 0); push(4, 0, 1);
        run_frame(4, 16, 1'b0, 11'd0, 0, 1);

        for (int i = 0; i < 16; i++) fbuf[i] = ((i % 4) >= 2) ? 100 : 0;
        push(4, 255, 0); push(4, 255, 0); push(4, 255, 0); push(4, 255, 1);
        run_frame(4, 16, 1'b0, 11'd0, 0, 0);

        for (int i = 0; i < 9; i++) fbuf[i] = 10 * (i + 1);
        push(3, 255, 1); run_frame(3, 9, 1'b0, 11'd0, 1, 0);

        // reset in the middle of a frame
        @(posedge clk); #1;
        start3 = 1'b1; mode = 1'b0;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pv = 1'b1; gray = 8'(fbuf[i]);
            @(posedge clk); #1;
        end
        pv = 1'b0;
        chk("busy mid-frame", busy3, 1);
        rst = 1'b1;
        #1;
        chk("mid reset busy3", busy3, 0);
        chk("mid reset valid3", valid3, 0);
        chk("mid reset done3", done3, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(3, 255, 1); run_frame(3, 9, 1'b0, 11'd0, 0, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
